// File: rtl/wram_arbiter_pkg.sv
// Shared constants and types for the WRAM arbiter.
//   WRAM_BASE..WRAM_TOP : direct work-RAM window (8 KiB)
//   ECHO_BASE..ECHO_TOP : mirror of the low 7.5 KiB of work RAM
//   OOB_DATA            : read value for accesses outside both windows
//   owner_e             : which requester holds / last held the port
//   ret_pipe_t          : read-return pipeline entry
package wram_arbiter_pkg;

  localparam logic [15:0] WRAM_BASE = 16'hC000;
  localparam logic [15:0] WRAM_TOP  = 16'hDFFF;
  localparam logic [15:0] ECHO_BASE = 16'hE000;
  localparam logic [15:0] ECHO_TOP  = 16'hFDFF;
  localparam logic [7:0]  OOB_DATA  = 8'hFF;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   oob;
  } ret_pipe_t;

endpackage

// File: rtl/wram_addr_decode.sv
// Work-RAM address decoder.
//   addr     : 16-bit CPU-space address of the winning request
//   in_range : address hits the WRAM window or its echo
//   ram_addr : 13-bit BRAM word address (echo folded onto WRAM)
module wram_addr_decode
  import wram_arbiter_pkg::*;
(
  input  logic [15:0] addr,
  output logic        in_range,
  output logic [12:0] ram_addr
);

  logic w_in_wram;
  logic w_in_echo;

  always_comb begin
    w_in_wram = (addr >= WRAM_BASE) && (addr <= WRAM_TOP);
    w_in_echo = (addr >= ECHO_BASE) && (addr <= ECHO_TOP);
    in_range  = w_in_wram || w_in_echo;
    ram_addr  = addr[12:0] - (w_in_echo ? ECHO_BASE[12:0] : WRAM_BASE[12:0]);
  end

endmodule

// File: rtl/wram_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single-port WRAM BRAM.
//   clk, rst                          : clock, synchronous active-high reset
//   cpu_req/we/addr/din -> cpu_ack    : CPU request, single-cycle grant pulse
//   cpu_rvalid, cpu_rdata             : CPU read return, one cycle after ack
//   dma_req/we/lock/addr/din, dma_ack : DMA request; lock keeps the port
//   dma_rvalid, dma_rdata             : DMA read return, one cycle after ack
//   ram_en/we/addr/din, ram_dout      : BRAM port, 1-cycle read latency
module wram_arbiter
  import wram_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic        cpu_rvalid,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_lock,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_din,
  output logic        dma_ack,
  output logic        dma_rvalid,
  output logic [7:0]  dma_rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [12:0] ram_addr,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout
);

  owner_e     r_last;
  ret_pipe_t  r_ret;
  logic [7:0] r_cpu_rdata;
  logic [7:0] r_dma_rdata;

  logic        w_grant;
  owner_e      w_win;
  logic        w_we;
  logic [15:0] w_addr;
  logic [7:0]  w_din;
  logic        w_in_range;
  logic [12:0] w_ram_addr;
  logic [7:0]  w_ret_data;

  always_comb begin
    w_grant = 1'b0;
    w_win   = OWN_CPU;
    if (!rst) begin
      if (cpu_req && dma_req) begin
        w_grant = 1'b1;
        // A held lock only pins the port while DMA is already the owner.
        if ((r_last == OWN_DMA) && dma_lock)
          w_win = OWN_DMA;
        else
          w_win = (r_last == OWN_CPU) ? OWN_DMA : OWN_CPU;
      end else if (cpu_req) begin
        w_grant = 1'b1;
        w_win   = OWN_CPU;
      end else if (dma_req) begin
        w_grant = 1'b1;
        w_win   = OWN_DMA;
      end
    end
  end

  always_comb begin
    w_we   = (w_win == OWN_DMA) ? dma_we   : cpu_we;
    w_addr = (w_win == OWN_DMA) ? dma_addr : cpu_addr;
    w_din  = (w_win == OWN_DMA) ? dma_din  : cpu_din;
  end

  wram_addr_decode u_decode (
    .addr     (w_addr),
    .in_range (w_in_range),
    .ram_addr (w_ram_addr)
  );

  always_comb begin
    cpu_ack  = w_grant && (w_win == OWN_CPU);
    dma_ack  = w_grant && (w_win == OWN_DMA);
    ram_en   = w_grant && w_in_range;
    ram_we   = ram_en && w_we;
    ram_addr = ram_en ? w_ram_addr : '0;
    ram_din  = ram_en ? w_din : '0;
  end

  // Return data is taken straight from the BRAM in the rvalid cycle, so the
  // hold registers only matter once rvalid has dropped.
  always_comb begin
    w_ret_data = r_ret.oob ? OOB_DATA : ram_dout;
    cpu_rvalid = !rst && r_ret.valid && (r_ret.owner == OWN_CPU);
    dma_rvalid = !rst && r_ret.valid && (r_ret.owner == OWN_DMA);
    cpu_rdata  = rst ? '0 : (cpu_rvalid ? w_ret_data : r_cpu_rdata);
    dma_rdata  = rst ? '0 : (dma_rvalid ? w_ret_data : r_dma_rdata);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last      <= OWN_DMA;
      r_ret       <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      if (w_grant)
        r_last <= w_win;
      r_ret <= '{valid: w_grant && !w_we, owner: w_win, oob: !w_in_range};
      if (cpu_rvalid)
        r_cpu_rdata <= w_ret_data;
      if (dma_rvalid)
        r_dma_rdata <= w_ret_data;
    end
  end

endmodule

// File: tb/tb_wram_arbiter.sv
// Testbench for wram_arbiter: directed scenarios plus randomized traffic
// against a memory-map level reference model.
module tb_wram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_ack, cpu_rvalid;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_rdata;
  logic        dma_req, dma_we, dma_lock, dma_ack, dma_rvalid;
  logic [15:0] dma_addr;
  logic [7:0]  dma_din, dma_rdata;
  logic        ram_en, ram_we;
  logic [12:0] ram_addr;
  logic [7:0]  ram_din, ram_dout;

  always #5 clk = ~clk;

  wram_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_din(dma_din), .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // BRAM: read-first, 1-cycle latency, preloaded on the first clock edge.
  logic [7:0] bram [0:8191];
  logic       bram_ready = 1'b0;
  always @(posedge clk) begin
    if (!bram_ready) begin
      for (int i = 0; i < 8192; i++) bram[i] <= 8'(i * 3);
      bram_ready <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) bram[ram_addr] <= ram_din;
      ram_dout <= bram[ram_addr];
    end
  end

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state: byte contents of the work RAM as seen from the
  // 16-bit address space, plus the single outstanding read return.
  logic [7:0]  ref_mem [0:8191];
  bit          m_last_dma;
  bit          m_pv, m_powner_dma;
  logic [7:0]  m_pdata, m_cpu_hold, m_dma_hold;

  bit          e_grant, e_win_dma, e_in, e_we;
  logic [12:0] e_off;
  logic [7:0]  e_din;
  bit          e_cpu_ack, e_dma_ack, e_ram_en, e_ram_we, e_cpu_rv, e_dma_rv;
  logic [7:0]  e_cpu_rdata, e_dma_rdata;

  function automatic bit map_addr(input logic [15:0] a, output logic [12:0] off);
    int unsigned v = a;
    if (v >= 32'hC000 && v <= 32'hDFFF) begin off = 13'(v - 32'hC000); return 1'b1; end
    if (v >= 32'hE000 && v <= 32'hFDFF) begin off = 13'(v - 32'hE000); return 1'b1; end
    off = '0;
    return 1'b0;
  endfunction

  task automatic model_eval();
    e_grant = 1'b0;
    e_win_dma = 1'b0;
    if (!rst) begin
      if (cpu_req && dma_req) begin
        e_grant = 1'b1;
        e_win_dma = (m_last_dma && dma_lock) ? 1'b1 : !m_last_dma;
      end else if (cpu_req) begin
        e_grant = 1'b1;
      end else if (dma_req) begin
        e_grant = 1'b1;
        e_win_dma = 1'b1;
      end
    end
    e_we  = e_win_dma ? dma_we : cpu_we;
    e_din = e_win_dma ? dma_din : cpu_din;
    e_in  = map_addr(e_win_dma ? dma_addr : cpu_addr, e_off);
    e_cpu_ack = e_grant && !e_win_dma;
    e_dma_ack = e_grant && e_win_dma;
    e_ram_en  = e_grant && e_in;
    e_ram_we  = e_ram_en && e_we;
    e_cpu_rv  = !rst && m_pv && !m_powner_dma;
    e_dma_rv  = !rst && m_pv && m_powner_dma;
    e_cpu_rdata = rst ? 8'h00 : (e_cpu_rv ? m_pdata : m_cpu_hold);
    e_dma_rdata = rst ? 8'h00 : (e_dma_rv ? m_pdata : m_dma_hold);
  endtask

  task automatic model_commit();
    if (rst) begin
      m_last_dma = 1'b1;
      m_pv = 1'b0;
      m_cpu_hold = 8'h00;
      m_dma_hold = 8'h00;
    end else begin
      if (e_cpu_rv) m_cpu_hold = m_pdata;
      if (e_dma_rv) m_dma_hold = m_pdata;
      m_pv = e_grant && !e_we;
      m_powner_dma = e_win_dma;
      if (e_grant && !e_we) m_pdata = e_in ? ref_mem[e_off] : 8'hFF;
      if (e_grant && e_we && e_in) ref_mem[e_off] = e_din;
      if (e_grant) m_last_dma = e_win_dma;
    end
  endtask

  task automatic settle();
    model_eval();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hC200; cpu_din = 8'h11;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'hC201; dma_din = 8'h22; dma_lock = 1'b0;
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++;
      if ({cpu_ack, dma_ack, ram_en, ram_we, cpu_rvalid, dma_rvalid} !== 6'b0) begin
        errors++;
        $display("FAIL reset_ctrl: got %b expected 000000",
                 {cpu_ack, dma_ack, ram_en, ram_we, cpu_rvalid, dma_rvalid});
      end
      checks++;
      if ({ram_addr, ram_din, cpu_rdata, dma_rdata} !== 37'h0) begin
        errors++;
        $display("FAIL reset_data: got %h expected 0", {ram_addr, ram_din, cpu_rdata, dma_rdata});
      end
      tick();
    end
  endtask

  task automatic test_contention();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      settle();
      checks++;
      if ({cpu_ack, dma_ack} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL contention_%0d: got cpu/dma ack %b%b expected %s", c, cpu_ack, dma_ack,
                 (c % 2 == 0) ? "10" : "01");
      end
      checks++;
      if (ram_addr !== ((c % 2 == 0) ? 13'h0200 : 13'h0201)) begin
        errors++;
        $display("FAIL contention_addr_%0d: got %h", c, ram_addr);
      end
      tick();
    end
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  task automatic test_cpu_only();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hC123; cpu_din = 8'h5A;
    settle();
    checks++;
    if ({cpu_ack, dma_ack, ram_en, ram_we, ram_addr, ram_din} !== {4'b1011, 13'h0123, 8'h5A}) begin
      errors++;
      $display("FAIL cpu_write: got %b%b%b%b %h %h expected 1011 0123 5a",
               cpu_ack, dma_ack, ram_en, ram_we, ram_addr, ram_din);
    end
    tick();
    cpu_we = 1'b0;
    settle();
    checks++;
    if ({cpu_ack, ram_en, ram_we, ram_addr} !== {3'b110, 13'h0123}) begin
      errors++;
      $display("FAIL cpu_read_ack: got %b%b%b %h expected 110 0123", cpu_ack, ram_en, ram_we, ram_addr);
    end
    tick();
    cpu_req = 1'b0;
    settle();
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL cpu_read_data: got rvalid=%b rdata=%h expected 1 5a", cpu_rvalid, cpu_rdata);
    end
    tick();
    settle();
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL cpu_rdata_hold: got rvalid=%b rdata=%h expected 0 5a", cpu_rvalid, cpu_rdata);
    end
    tick();
  endtask

  task automatic test_echo();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hE010; cpu_din = 8'h3C;
    settle();
    checks++;
    if ({cpu_ack, ram_en, ram_we, ram_addr} !== {3'b111, 13'h0010}) begin
      errors++;
      $display("FAIL echo_write: got %b%b%b %h expected 111 0010", cpu_ack, ram_en, ram_we, ram_addr);
    end
    tick();
    cpu_req = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'hC010;
    settle();
    checks++;
    if (dma_ack !== 1'b1) begin errors++; $display("FAIL echo_dma_ack: got %b expected 1", dma_ack); end
    tick();
    dma_req = 1'b0;
    settle();
    checks++;
    if (dma_rvalid !== 1'b1 || dma_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL echo_dma_read: got rvalid=%b rdata=%h expected 1 3c", dma_rvalid, dma_rdata);
    end
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFE00;
    settle();
    checks++;
    if ({cpu_ack, ram_en, ram_we} !== 3'b100) begin
      errors++;
      $display("FAIL oob_ack: got %b%b%b expected 100", cpu_ack, ram_en, ram_we);
    end
    tick();
    cpu_req = 1'b0;
    settle();
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hFF) begin
      errors++;
      $display("FAIL oob_read: got rvalid=%b rdata=%h expected 1 ff", cpu_rvalid, cpu_rdata);
    end
    tick();
  endtask

  task automatic test_lock();
    dma_req = 1'b1; dma_we = 1'b1; dma_lock = 1'b1; dma_addr = 16'hC300; dma_din = 8'h01;
    settle();
    checks++;
    if (dma_ack !== 1'b1) begin errors++; $display("FAIL lock_first: got %b expected 1", dma_ack); end
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hC301; cpu_din = 8'h02;
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++;
      if ({cpu_ack, dma_ack} !== 2'b01) begin
        errors++;
        $display("FAIL lock_hold_%0d: got cpu/dma %b%b expected 01", c, cpu_ack, dma_ack);
      end
      tick();
    end
    dma_lock = 1'b0;
    settle();
    checks++;
    if ({cpu_ack, dma_ack} !== 2'b10) begin
      errors++;
      $display("FAIL lock_release: got cpu/dma %b%b expected 10", cpu_ack, dma_ack);
    end
    tick();
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    cpu_req = 1'b1; cpu_we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cpu_addr = 16'hD000 + 16'(k);
      cpu_din  = 8'hA0 + 8'(k);
      settle();
      checks++;
      if (cpu_ack !== 1'b1) begin errors++; $display("FAIL b2b_wr_%0d: got %b expected 1", k, cpu_ack); end
      tick();
    end
    cpu_req = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) dma_addr = 16'hD000 + 16'(k);
      else dma_req = 1'b0;
      settle();
      if (k < 4) begin
        checks++;
        if (dma_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack_%0d: got %b expected 1", k, dma_ack); end
      end
      if (k > 0) begin
        checks++;
        if (dma_rvalid !== 1'b1 || dma_rdata !== 8'hA0 + 8'(k - 1)) begin
          errors++;
          $display("FAIL b2b_rd_%0d: got rvalid=%b rdata=%h expected 1 %h", k - 1, dma_rvalid,
                   dma_rdata, 8'hA0 + 8'(k - 1));
        end
      end
      tick();
    end
    settle();
    checks++;
    if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end: got rvalid=%b expected 0", dma_rvalid); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hC123;
    settle();
    checks++;
    if (cpu_ack !== 1'b1) begin errors++; $display("FAIL midrst_ack: got %b expected 1", cpu_ack); end
    tick();
    cpu_req = 1'b0;
    rst = 1'b1;
    settle();
    checks++;
    if ({cpu_ack, dma_ack, ram_en, ram_we, cpu_rvalid, dma_rvalid, ram_addr, ram_din, cpu_rdata, dma_rdata}
        !== 43'h0) begin
      errors++;
      $display("FAIL midrst_outputs: got rvalid=%b rdata=%h ram_en=%b expected all 0",
               cpu_rvalid, cpu_rdata, ram_en);
    end
    tick();
    rst = 1'b0;
    settle();
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'h00) begin
      errors++;
      $display("FAIL midrst_after: got rvalid=%b rdata=%h expected 0 00", cpu_rvalid, cpu_rdata);
    end
    tick();
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 7))
      0, 1, 2: return 16'hC000 + 16'($urandom_range(0, 31));
      3, 4:    return 16'hE000 + 16'($urandom_range(0, 31));
      5:       return 16'($urandom);
      6: begin
        case ($urandom_range(0, 5))
          0: return 16'hBFFF;
          1: return 16'hDFFF;
          2: return 16'hE000;
          3: return 16'hFDFF;
          4: return 16'hFE00;
          default: return 16'hC000;
        endcase
      end
      default: return 16'hDDFF;
    endcase
  endfunction

  task automatic test_random();
    bit cpu_busy = 1'b0;
    bit dma_busy = 1'b0;
    bit cpu_done, dma_done;
    for (int c = 0; c < 600; c++) begin
      if (!cpu_busy && $urandom_range(0, 3) != 0) begin
        cpu_busy = 1'b1; cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = rand_addr(); cpu_din = 8'($urandom);
      end
      if (!dma_busy && $urandom_range(0, 3) != 0) begin
        dma_busy = 1'b1; dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1));
        dma_addr = rand_addr(); dma_din = 8'($urandom);
      end
      dma_lock = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 99) == 0);
      settle();
      checks++;
      if ({cpu_ack, dma_ack} !== {e_cpu_ack, e_dma_ack} || (cpu_ack && dma_ack)) begin
        errors++;
        $display("FAIL rand_ack c%0d: got %b%b expected %b%b", c, cpu_ack, dma_ack, e_cpu_ack, e_dma_ack);
      end
      checks++;
      if ({ram_en, ram_we} !== {e_ram_en, e_ram_we}) begin
        errors++;
        $display("FAIL rand_ram_ctl c%0d: got %b%b expected %b%b", c, ram_en, ram_we, e_ram_en, e_ram_we);
      end
      if (e_ram_en) begin
        checks++;
        if (ram_addr !== e_off || ram_din !== e_din) begin
          errors++;
          $display("FAIL rand_ram_port c%0d: got %h/%h expected %h/%h", c, ram_addr, ram_din, e_off, e_din);
        end
      end
      checks++;
      if ({cpu_rvalid, dma_rvalid} !== {e_cpu_rv, e_dma_rv}) begin
        errors++;
        $display("FAIL rand_rvalid c%0d: got %b%b expected %b%b", c, cpu_rvalid, dma_rvalid, e_cpu_rv, e_dma_rv);
      end
      checks++;
      if (cpu_rdata !== e_cpu_rdata || dma_rdata !== e_dma_rdata) begin
        errors++;
        $display("FAIL rand_rdata c%0d: got %h/%h expected %h/%h", c, cpu_rdata, dma_rdata,
                 e_cpu_rdata, e_dma_rdata);
      end
      cpu_done = e_cpu_ack;
      dma_done = e_dma_ack;
      tick();
      if (cpu_done) begin cpu_busy = 1'b0; cpu_req = 1'b0; end
      if (dma_done) begin dma_busy = 1'b0; dma_req = 1'b0; end
    end
    rst = 1'b0; cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0; dma_addr = '0; dma_din = '0;
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'(i * 3);
    m_last_dma = 1'b1; m_pv = 1'b0; m_powner_dma = 1'b0;
    m_pdata = '0; m_cpu_hold = '0; m_dma_hold = '0;

    test_reset();
    test_contention();
    test_cpu_only();
    test_echo();
    test_lock();
    test_back_to_back();
    test_reset_mid_read();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
